// File: rtl/fcore_pkg.sv
// rtl/fcore_pkg.sv - shared FSM states and register-address helper for the fcore DMA reader
package fcore_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } fcore_state_e;

    // Flat register-file address of register reg_idx inside channel.
    function automatic logic [31:0] compose_addr(
        input logic [31:0] channel,
        input logic [31:0] reg_idx,
        input logic [31:0] reg_per_channel
    );
        return channel * reg_per_channel + reg_idx;
    endfunction

endpackage

// File: rtl/axi_stream.sv
// rtl/axi_stream.sv - stream interface carrying data, dest, user and last with valid/ready
interface axi_stream #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 6,
    parameter int USER_W = 2
);
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
    logic [USER_W-1:0] user;
    logic              last;
    logic              valid;
    logic              ready;

    modport master (output data, dest, user, last, valid, input ready);
    modport slave  (input data, dest, user, last, valid, output ready);
endinterface

// File: rtl/fcore_reader_skid.sv
// rtl/fcore_reader_skid.sv - 2-entry fall-through buffer between register-file returns and the stream
module fcore_reader_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_tvalid,
    input  logic [W-1:0] s_tdata,
    output logic         m_tvalid,
    output logic [W-1:0] m_tdata,
    input  logic         m_tready,
    output logic [1:0]   count
);
    logic [W-1:0] mem_q [2];
    logic         rd_q;
    logic         wr_q;
    logic [1:0]   count_q;
    logic         empty;
    logic         push;
    logic         pop;

    assign empty = (count_q == 2'd0);
    // A returning word bypasses storage when the buffer is empty and the sink takes it now.
    assign push  = s_tvalid && !(empty && m_tready);
    assign pop   = !empty && m_tready;

    assign m_tvalid = !empty || s_tvalid;
    assign m_tdata  = !empty ? mem_q[rd_q] : (s_tvalid ? s_tdata : '0);
    assign count    = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= s_tdata;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fcore_dma_reader.sv
// rtl/fcore_dma_reader.sv - sweeps a per-channel register window over the DMA port and streams it out
// Optional: FCORE_READER_ZERO_SKIP_EN skips each channel's hardwired-zero register 0.
module fcore_dma_reader
    import fcore_pkg::*;
#(
    parameter int REGISTER_WIDTH  = 32,
    parameter int FILE_DEPTH      = 64,
    parameter int REG_PER_CHANNEL = 16,
    parameter int N_CHANNELS      = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [$clog2(N_CHANNELS):0]         n_channels,
    input  logic [$clog2(REG_PER_CHANNEL)-1:0]  first_reg,
    input  logic [$clog2(REG_PER_CHANNEL)-1:0]  last_reg,
    output logic                                dma_enable,
    output logic [$clog2(FILE_DEPTH)-1:0]       dma_read_addr,
    input  logic [REGISTER_WIDTH-1:0]           dma_read_data,
    axi_stream.master                           data_out,
    output logic                                busy,
    output logic                                done
);
    localparam int A_W       = $clog2(FILE_DEPTH);
    localparam int R_W       = $clog2(REG_PER_CHANNEL);
    localparam int NC_W      = $clog2(N_CHANNELS) + 1;
    localparam int U_W       = $clog2(N_CHANNELS);
    localparam int PAYLOAD_W = REGISTER_WIDTH + A_W + U_W + 1;

    fcore_state_e   state_q;
    logic [NC_W-1:0] n_ch_q;
    logic [R_W-1:0]  first_q;
    logic [R_W-1:0]  last_q;
    logic [NC_W-1:0] ch_q;
    logic [R_W-1:0]  reg_q;
    logic            fl_valid_q;
    logic [A_W-1:0]  fl_addr_q;
    logic [U_W-1:0]  fl_user_q;
    logic            fl_last_q;
    logic            done_q;

    logic [R_W-1:0]       eff_first;
    logic                 cfg_empty;
    logic [1:0]           skid_count;
    logic                 room;
    logic                 issue;
    logic                 final_issue;
    logic [A_W-1:0]       issue_addr;
    logic                 skid_tvalid;
    logic [PAYLOAD_W-1:0] skid_tdata;
    logic                 last_accept;

`ifdef FCORE_READER_ZERO_SKIP_EN
    // Register 0 of every channel reads as zero, so the window simply starts one later.
    assign eff_first = (first_reg == '0) ? R_W'(1) : first_reg;
`else
    assign eff_first = first_reg;
`endif

    assign cfg_empty = (n_channels == '0) || (n_channels > NC_W'(N_CHANNELS)) ||
                       (eff_first > last_reg);

    // Buffered words plus the read in flight must leave room for one more return.
    assign room        = (skid_count == 2'd0) || ((skid_count == 2'd1) && !fl_valid_q);
    assign issue       = (state_q == READ) && room;
    assign final_issue = issue && (ch_q == n_ch_q - NC_W'(1)) && (reg_q == last_q);
    assign issue_addr  = A_W'(compose_addr(32'(ch_q), 32'(reg_q), 32'(REG_PER_CHANNEL)));

    assign dma_enable    = (state_q == READ) || fl_valid_q;
    assign dma_read_addr = issue ? issue_addr : '0;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            n_ch_q     <= '0;
            first_q    <= '0;
            last_q     <= '0;
            ch_q       <= '0;
            reg_q      <= '0;
            fl_valid_q <= 1'b0;
            fl_addr_q  <= '0;
            fl_user_q  <= '0;
            fl_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            fl_valid_q <= issue;
            fl_addr_q  <= issue ? issue_addr : '0;
            fl_user_q  <= issue ? ch_q[U_W-1:0] : '0;
            fl_last_q  <= final_issue;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_empty) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= READ;
                            n_ch_q  <= n_channels;
                            first_q <= eff_first;
                            last_q  <= last_reg;
                            ch_q    <= '0;
                            reg_q   <= eff_first;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        if (reg_q == last_q) begin
                            reg_q <= first_q;
                            ch_q  <= ch_q + NC_W'(1);
                        end else begin
                            reg_q <= reg_q + R_W'(1);
                        end
                        if (final_issue) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_accept) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fcore_reader_skid #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tvalid (fl_valid_q),
        .s_tdata  ({dma_read_data, fl_addr_q, fl_user_q, fl_last_q}),
        .m_tvalid (skid_tvalid),
        .m_tdata  (skid_tdata),
        .m_tready (data_out.ready),
        .count    (skid_count)
    );

    assign last_accept    = skid_tvalid && data_out.ready && skid_tdata[0];
    assign data_out.valid = skid_tvalid;
    assign data_out.data  = skid_tdata[PAYLOAD_W-1 -: REGISTER_WIDTH];
    assign data_out.dest  = skid_tdata[A_W+U_W:U_W+1];
    assign data_out.user  = skid_tdata[U_W:1];
    assign data_out.last  = skid_tdata[0];

endmodule

// File: tb/tb_fcore_dma_reader.sv
// tb/tb_fcore_dma_reader.sv - randomized sweeps of fcore_dma_reader checked against a queue-based model
module tb_fcore_dma_reader;
    localparam int RW   = 32;
    localparam int FD   = 64;
    localparam int RPC  = 16;
    localparam int NCH  = 4;
    localparam int AW   = $clog2(FD);
    localparam int RGW  = $clog2(RPC);
    localparam int NCW  = $clog2(NCH) + 1;
    localparam int UW   = $clog2(NCH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [NCW-1:0] n_channels = '0;
    logic [RGW-1:0] first_reg = '0;
    logic [RGW-1:0] last_reg = '0;
    logic           dma_enable;
    logic [AW-1:0]  dma_read_addr;
    logic [RW-1:0]  dma_read_data;
    logic           busy;
    logic           done;
    logic [RW-1:0]  regfile [FD];
    beat_t          exp_q [$];
    int             checks = 0;
    int             errors = 0;

    axi_stream #(.DATA_W(RW), .DEST_W(AW), .USER_W(UW)) data_out ();

    fcore_dma_reader #(
        .REGISTER_WIDTH  (RW),
        .FILE_DEPTH      (FD),
        .REG_PER_CHANNEL (RPC),
        .N_CHANNELS      (NCH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .n_channels    (n_channels),
        .first_reg     (first_reg),
        .last_reg      (last_reg),
        .dma_enable    (dma_enable),
        .dma_read_addr (dma_read_addr),
        .dma_read_data (dma_read_data),
        .data_out      (data_out),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Register file: data for the address presented in one cycle appears in the next.
    always @(posedge clk) dma_read_data <= dma_enable ? regfile[dma_read_addr] : $urandom();

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_dma_enable"}, 64'(dma_enable), 64'(0));
        chk({pfx, "_dma_addr"}, 64'(dma_read_addr), 64'(0));
        chk({pfx, "_valid"}, 64'(data_out.valid), 64'(0));
        chk({pfx, "_data"}, 64'(data_out.data), 64'(0));
        chk({pfx, "_dest"}, 64'(data_out.dest), 64'(0));
        chk({pfx, "_user"}, 64'(data_out.user), 64'(0));
        chk({pfx, "_last"}, 64'(data_out.last), 64'(0));
        chk({pfx, "_busy"}, 64'(busy), 64'(0));
        chk({pfx, "_done"}, 64'(done), 64'(0));
    endtask

    // Expected beats straight from the sweep rules: channels outer, registers inner.
    task automatic build_model(input int n, input int f, input int l);
        exp_q.delete();
        if (n < 1 || n > NCH || f > l) return;
        for (int c = 0; c < n; c++) begin
            for (int r = f; r <= l; r++) begin
                int a;
                a = c * RPC + r;
`ifdef FCORE_READER_ZERO_SKIP_EN
                if (a % RPC == 0) continue;
`endif
                exp_q.push_back('{addr: AW'(a), user: UW'(c), last: 1'b0});
            end
        end
        if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
    endtask

    // mode: 0 ready held high, 1 ready toggling 1-0-1-0, 2 random ready.
    task automatic run_sweep(input int n, input int f, input int l, input int mode,
                             input int reset_at, input bit restart);
        int            nexp;
        int            beats;
        int            first_cyc;
        int            done_cyc;
        bit            en_seen;
        bit            prev_hold;
        logic [63:0]   prev_payload;
        beat_t         e;
        build_model(n, f, l);
        nexp      = exp_q.size();
        beats     = 0;
        first_cyc = -1;
        done_cyc  = -1;
        en_seen   = 1'b0;
        prev_hold = 1'b0;
        prev_payload = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 0) begin
                start      = 1'b1;
                n_channels = NCW'(n);
                first_reg  = RGW'(f);
                last_reg   = RGW'(l);
            end else begin
                start      = restart && (cyc == 10);
                n_channels = NCW'($urandom_range(0, 7));
                first_reg  = RGW'($urandom());
                last_reg   = RGW'($urandom());
            end
            case (mode)
                0:       data_out.ready = 1'b1;
                1:       data_out.ready = (cyc % 2 == 0);
                default: data_out.ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (dma_enable) en_seen = 1'b1;
            if (prev_hold) begin
                chk("hold_valid", 64'(data_out.valid), 64'(1));
                chk("hold_payload",
                    64'({data_out.data, data_out.dest, data_out.user, data_out.last}),
                    prev_payload);
            end
            if (data_out.valid && data_out.ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(beats + 1), 64'(nexp));
                end else begin
                    e = exp_q.pop_front();
                    chk("dest", 64'(data_out.dest), 64'(e.addr));
                    chk("user", 64'(data_out.user), 64'(e.user));
                    chk("last", 64'(data_out.last), 64'(e.last));
                    chk("data", 64'(data_out.data), 64'(regfile[e.addr]));
                end
                beats++;
                if (beats == reset_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_zero("midreset");
                    @(posedge clk);
                    @(negedge clk);
                    #1;
                    check_zero("midreset_hold");
                    rst_n = 1'b1;
                    start = 1'b0;
                    @(negedge clk);
                    return;
                end
            end
            prev_hold    = data_out.valid && !data_out.ready;
            prev_payload = 64'({data_out.data, data_out.dest, data_out.user, data_out.last});
            if (cyc == 1 && nexp > 0) chk("busy_during", 64'(busy), 64'(1));
            if (done) begin
                done_cyc = cyc;
                chk("busy_at_done", 64'(busy), 64'(0));
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 64'(done_cyc >= 0), 64'(1));
        chk("beat_count", 64'(beats), 64'(nexp));
        if (nexp == 0) begin
            chk("empty_done_cycle", 64'(done_cyc), 64'(1));
            chk("empty_dma_enable", 64'(en_seen), 64'(0));
        end else if (mode == 0) begin
            chk("first_beat_cycle", 64'(first_cyc), 64'(2));
            chk("done_cycle", 64'(done_cyc), 64'(2 + nexp));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("done_pulse_width", 64'(done), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < FD; i++) regfile[i] = $urandom();
        data_out.ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(2, 0, 15, 0, -1, 1'b0);
        run_sweep(2, 0, 15, 1, -1, 1'b0);
        run_sweep(2, 0, 15, 2, -1, 1'b0);
        run_sweep(2, 5, 3, 2, -1, 1'b0);
        run_sweep(0, 0, 15, 0, -1, 1'b0);
        run_sweep(5, 0, 15, 0, -1, 1'b0);
        run_sweep(2, 0, 3, 0, -1, 1'b0);
        run_sweep(2, 0, 15, 2, 7, 1'b0);
        run_sweep(2, 0, 15, 2, -1, 1'b0);
        run_sweep(4, 0, 15, 2, -1, 1'b1);
        run_sweep(2, 0, 15, 0, -1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            int f;
            int l;
            f = $urandom_range(0, RPC - 1);
            l = $urandom_range(f, RPC - 1);
            run_sweep($urandom_range(1, NCH), f, l, $urandom_range(0, 2), -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
